// File: rtl/idelay_tap_ctrl_pkg.sv
// Shared definitions for the IDELAY tap controller: tap width, command codes
// and FSM state encoding.
package idelay_tap_pkg;

  localparam int TAP_W = 5;
  localparam logic [TAP_W-1:0] TAP_MAX = 5'd31;

  typedef enum logic [1:0] {
    CMD_SET  = 2'b00,
    CMD_INC1 = 2'b01,
    CMD_DEC1 = 2'b10,
    CMD_LOAD = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_STEP   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/idelay_tap_ctrl_if.sv
// Command request channel of the IDELAY tap controller (valid/ready handshake).
interface idelay_tap_ctrl_if;
  import idelay_tap_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_cmd;
  logic [TAP_W-1:0] req_tap;

  modport master (output req_valid, req_cmd, req_tap, input req_ready);
  modport slave  (input req_valid, req_cmd, req_tap, output req_ready);

endinterface

// File: rtl/idelay_tap_ctrl.sv
// Steps an IDELAY element one tap at a time towards a commanded value, with a
// settle gap after every CE/LD strobe and a tracked copy of the current tap.
module idelay_tap_ctrl
  import idelay_tap_pkg::*;
#(
  parameter int IDELAY_VALUE  = 0,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  idelay_tap_ctrl_if.slave req,
  output logic             dly_ce,
  output logic             dly_inc,
  output logic             dly_ld,
  output logic [TAP_W-1:0] cur_tap,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [TAP_W-1:0] LP_IV        = TAP_W'(IDELAY_VALUE);
  localparam logic [7:0]       LP_SETTLE    = 8'(SETTLE_CYCLES);
  localparam logic [7:0]       LP_SETTLE_M1 = LP_SETTLE - 8'd1;

  state_e           r_state;
  cmd_e             r_cmd;
  logic [TAP_W-1:0] r_target;
  logic [TAP_W-1:0] r_cur_tap;
  logic             r_inc;
  logic             r_sat;
  logic             r_boot;
  logic [7:0]       r_settle_cnt;

  state_e           w_state_nxt;
  cmd_e             w_req_cmd;
  logic [TAP_W-1:0] w_tgt;
  logic             w_dir;
  logic             w_sat;
  logic             w_accept;
  logic             w_step_ce;
  logic             w_step_ld;
  logic [TAP_W-1:0] w_next_tap;

  assign w_req_cmd = cmd_e'(req.req_cmd);
  assign w_accept  = (r_state == ST_IDLE) && req.req_valid;
  assign w_step_ce = (r_state == ST_STEP) && (r_cmd != CMD_LOAD) && (r_target != r_cur_tap);
  assign w_step_ld = (r_state == ST_STEP) && (r_cmd == CMD_LOAD);

  // Target and direction for the request on the bus; saturating INC1/DEC1 keep the tap.
  always_comb begin
    w_tgt = r_cur_tap;
    w_dir = 1'b0;
    w_sat = 1'b0;
    case (w_req_cmd)
      CMD_SET: begin
        w_tgt = req.req_tap;
        w_dir = (req.req_tap > r_cur_tap);
      end
      CMD_INC1: begin
        w_dir = 1'b1;
        if (r_cur_tap == TAP_MAX) w_sat = 1'b1;
        else                      w_tgt = r_cur_tap + 1'b1;
      end
      CMD_DEC1: begin
        if (r_cur_tap == '0) w_sat = 1'b1;
        else                 w_tgt = r_cur_tap - 1'b1;
      end
      CMD_LOAD: begin
        w_tgt = LP_IV;
        w_dir = (LP_IV > r_cur_tap);
      end
      default: ;
    endcase
  end

  always_comb begin
    w_next_tap = r_cur_tap;
    if (w_step_ce)      w_next_tap = r_inc ? (r_cur_tap + 1'b1) : (r_cur_tap - 1'b1);
    else if (w_step_ld) w_next_tap = LP_IV;
  end

  // The "target reached" test is made on leaving IDLE/SETTLE rather than in STEP,
  // so DONE follows the last settle period directly without an extra STEP cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT:   w_state_nxt = (LP_SETTLE == 8'd0) ? ST_IDLE : ST_SETTLE;
      ST_IDLE: begin
        if (w_accept)
          w_state_nxt = ((w_req_cmd != CMD_LOAD) && (w_tgt == r_cur_tap)) ? ST_DONE : ST_STEP;
      end
      ST_STEP: begin
        if (LP_SETTLE != 8'd0)           w_state_nxt = ST_SETTLE;
        else if (w_next_tap == r_target) w_state_nxt = ST_DONE;
      end
      ST_SETTLE: begin
        if (r_settle_cnt == 8'd0) begin
          if (r_boot)                       w_state_nxt = ST_IDLE;
          else if (r_cur_tap == r_target)   w_state_nxt = ST_DONE;
          else                              w_state_nxt = ST_STEP;
        end
      end
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= ST_INIT;
      r_cmd        <= CMD_SET;
      r_target     <= LP_IV;
      r_cur_tap    <= LP_IV;
      r_inc        <= 1'b0;
      r_sat        <= 1'b0;
      r_boot       <= 1'b1;
      r_settle_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cur_tap <= w_next_tap;
      if (w_accept) begin
        r_cmd    <= w_req_cmd;
        r_target <= w_tgt;
        r_inc    <= w_dir;
        r_sat    <= w_sat;
      end
      if (w_state_nxt == ST_IDLE) r_boot <= 1'b0;
      if ((w_state_nxt == ST_SETTLE) && (r_state != ST_SETTLE))
        r_settle_cnt <= LP_SETTLE_M1;
      else if ((r_state == ST_SETTLE) && (r_settle_cnt != 8'd0))
        r_settle_cnt <= r_settle_cnt - 8'd1;
    end
  end

  // INIT's LD is gated by RST_N so it stays low while reset holds the FSM in INIT.
  assign dly_ld        = w_step_ld || ((r_state == ST_INIT) && RST_N);
  assign dly_ce        = w_step_ce;
  assign dly_inc       = r_inc;
  assign cur_tap       = r_cur_tap;
  assign busy          = (r_state != ST_IDLE);
  assign done          = (r_state == ST_DONE);
  assign err           = (r_state == ST_DONE) && r_sat;
  assign req.req_ready = (r_state == ST_IDLE);

endmodule
